alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit bitwise logic unit (AND and sibling ops).
- Captures each 32-bit result together with its opcode tag, computes status flags (zero, negative, parity) at capture, and buffers up to two results in a 2-entry skid FIFO.
- Uses a valid/ready handshake, so a stalled consumer (writeback/register file) never drops a result.
- Keeps a running count of delivered results for debug.

Parameters:
- W, 32, data width of result path
- OPW, 4, width of opcode tag carried alongside result
- CNTW, 16, width of delivered-result counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result this cycle
- in_f  input  W  result word from logic unit
- in_op  input  OPW  opcode tag of that result
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry
- out_f  output  W  head result word
- out_op  output  OPW  head opcode tag
- out_zero  output  1  head result == 0
- out_neg  output  1  head result bit W-1
- out_parity  output  1  XOR-reduction of head result (1 = odd number of ones)
- out_count  output  CNTW  number of results delivered since reset

Behaviour:
- Reset (async assert, sync release): occupancy=0, rd_ptr=wr_ptr=0, in_ready=1, out_valid=0, out_f=0, out_op=0, all flags 0, out_count=0. Reset mid-transfer discards buffered entries; no partial outputs.
- Storage: 2 entries, each {f, op, zero, neg, parity}. Flags are computed from in_f at the push edge and stored, so flags never change while an entry is at the head.
- Push: in_valid & in_ready at a rising edge writes entry[wr_ptr]; wr_ptr toggles.
- Pop: out_valid & out_ready at a rising edge retires entry[rd_ptr]; rd_ptr toggles; out_count increments by 1 and wraps modulo 2^CNTW (no saturation).
- Occupancy states: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push only -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE.
  - FULL: pop -> ONE; push is impossible (in_ready=0).
- in_ready = (occupancy != FULL). It is driven from registered state only, with no combinational path from out_ready. A pop at FULL therefore does not enable a push in the same cycle.
- out_valid = (occupancy != EMPTY).
- out_f, out_op and flags present entry[rd_ptr]. When out_valid=0 they hold their last values (0 after reset).
- Latency: a result pushed at edge N is visible at the outputs after edge N (one cycle) when the buffer was empty. No bypass path.
- Ordering: strict FIFO; results leave in push order.
- Stability: while out_valid=1 and out_ready=0, out_f, out_op and flags must not change.
- Upstream obligation: in_f/in_op must be stable while in_valid=1 and in_ready=0. This stage does not check it.
- Throughput: one result per cycle sustained when out_ready is held at 1.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, out_count=0, outputs 0. Assert rst_n=0 mid-stream with 2 entries held -> out_valid=0, in_ready=1 immediately (async).
- Push in_f=32'h0000_0000 op=4'h1 with out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_parity=0. Popped that cycle; out_count=1.
- Push 32'h8000_0001 then 32'h0000_0007 with out_ready=0 -> FULL, in_ready=0. Head shows neg=1, parity=0, zero=0 and is stable for 5 stalled cycles. Release out_ready -> 32'h8000_0001 then 32'h0000_0007 (parity=1) in order.
- FULL with in_valid=1 and out_ready=1 in the same cycle -> exactly one pop, no push that cycle, in_ready=1 next cycle, third word not lost.
- Back-to-back 100 pushes of i*32'h0101_0101 with out_ready=1 -> one output per cycle, data and flags match reference model, out_count=100.
- Preset 65535 deliveries (or force counter), pop one more -> out_count wraps to 0.

Source files
------------

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered, flag-annotated 2-entry skid output stage for the logic unit
//
// Purpose:
//   Captures each result from the 32-bit bitwise logic unit with its opcode
//   tag, computes zero/negative/parity flags at capture time, and holds up to
//   two results so a stalled consumer never drops one. Counts delivered
//   results for debug.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream result valid
//   in_ready    stage can accept a result this cycle (registered state only)
//   in_f        result word from the logic unit
//   in_op       opcode tag of that result
//   out_valid   head entry valid
//   out_ready   consumer accepts head entry
//   out_f       head result word
//   out_op      head opcode tag
//   out_zero    head result == 0
//   out_neg     head result sign bit
//   out_parity  XOR-reduction of head result (1 = odd number of ones)
//   out_count   results delivered since reset, wraps

module alu_result_stage #(
  parameter int W    = 32,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_f,
  input  logic [OPW-1:0]  in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_f,
  output logic [OPW-1:0]  out_op,
  output logic            out_zero,
  output logic            out_neg,
  output logic            out_parity,
  output logic [CNTW-1:0] out_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t state_q, state_d;

  logic rd_ptr_q, wr_ptr_q;
  logic rd_ptr_d;
  logic push, pop;

  // Entry storage; flags are packed as {zero, neg, parity}.
  logic [W-1:0]   f_mem    [2];
  logic [OPW-1:0] op_mem   [2];
  logic [2:0]     flag_mem [2];

  logic [2:0]     in_flags;

  // Registered head presentation; holds its last value while empty.
  logic [W-1:0]   head_f_q,    head_f_d;
  logic [OPW-1:0] head_op_q,   head_op_d;
  logic [2:0]     head_flag_q, head_flag_d;
  logic           head_load;
  logic           head_from_input;

  logic [CNTW-1:0] count_q;

  // ---------------------------------------------------------------------------
  // Occupancy FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (push) state_d = ONE;
      end
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL: begin
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: outputs
  // in_ready depends only on the state register, so a pop while FULL cannot
  // open the input in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign rd_ptr_d = rd_ptr_q ^ pop;

  // ---------------------------------------------------------------------------
  // Entry storage; flags are frozen at capture.
  // ---------------------------------------------------------------------------
  assign in_flags = {(in_f == '0), in_f[W-1], ^in_f};

  always_ff @(posedge clk) begin
    if (push) begin
      f_mem[wr_ptr_q]    <= in_f;
      op_mem[wr_ptr_q]   <= in_op;
      flag_mem[wr_ptr_q] <= in_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation
  // The output registers are loaded with whatever entry will sit at the head
  // after this edge. If that slot is being written in the same edge (empty
  // buffer, or ONE with simultaneous push and pop) the incoming word is taken
  // directly, since the memory does not hold it yet. When the buffer drains
  // the registers are left alone so the outputs keep their last values.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_from_input = push && (rd_ptr_d == wr_ptr_q);
    head_load       = (state_d != EMPTY);
    if (head_from_input) begin
      head_f_d    = in_f;
      head_op_d   = in_op;
      head_flag_d = in_flags;
    end else begin
      head_f_d    = f_mem[rd_ptr_d];
      head_op_d   = op_mem[rd_ptr_d];
      head_flag_d = flag_mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_f_q    <= '0;
      head_op_q   <= '0;
      head_flag_q <= '0;
    end else if (head_load) begin
      head_f_q    <= head_f_d;
      head_op_q   <= head_op_d;
      head_flag_q <= head_flag_d;
    end
  end

  assign out_f      = head_f_q;
  assign out_op     = head_op_q;
  assign out_zero   = head_flag_q[2];
  assign out_neg    = head_flag_q[1];
  assign out_parity = head_flag_q[0];

  // ---------------------------------------------------------------------------
  // Delivered-result counter, wraps modulo 2^CNTW
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + CNTW'(1);
    end
  end

  assign out_count = count_q;

endmodule
